// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RV32I core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause, the 64-bit mcycle and
// minstret counters with their read-only aliases, and resolves trap/MRET
// updates against CSR instruction writes.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  uimm_in,
    input  logic        instret_inc_in,
    input  logic        trap_in,
    input  logic [31:0] trap_cause_in,
    input  logic [31:0] trap_pc_in,
    input  logic        mret_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_global_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    // Architectural state
    logic        mie_q,       mie_d;
    logic        mpie_q,      mpie_d;
    logic [31:0] mie_reg_q,   mie_reg_d;
    logic [31:0] mtvec_q,     mtvec_d;
    logic [31:0] mscratch_q,  mscratch_d;
    logic [31:0] mepc_q,      mepc_d;
    logic [31:0] mcause_q,    mcause_d;
    logic [63:0] mcycle_q,    mcycle_d;
    logic [63:0] minstret_q,  minstret_d;

    logic [31:0] mstatus_val;
    logic [31:0] rdata;
    logic        implemented;
    logic        read_only;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        op_valid;
    logic        csr_we;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    // Combinational read mux: pre-write value of the addressed CSR.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rdata       = 32'h0;
        implemented = 1'b1;
        case (csr_addr_in)
            ADDR_MSTATUS:                  rdata = mstatus_val;
            ADDR_MISA:                     rdata = MISA_VALUE;
            ADDR_MIE:                      rdata = mie_reg_q;
            ADDR_MTVEC:                    rdata = mtvec_q;
            ADDR_MSCRATCH:                 rdata = mscratch_q;
            ADDR_MEPC:                     rdata = mepc_q;
            ADDR_MCAUSE:                   rdata = mcause_q;
            ADDR_MCYCLE,   ADDR_CYCLE:     rdata = mcycle_q[31:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:    rdata = mcycle_q[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:   rdata = minstret_q[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: rdata = minstret_q[63:32];
            ADDR_MHARTID:                  rdata = 32'h0;
            default:                       implemented = 1'b0;
        endcase
    end

    assign csr_data_out    = rdata;
    assign read_only       = (csr_addr_in[11:10] == 2'b11) || (csr_addr_in == ADDR_MISA);
    assign illegal_csr_out = !implemented || (wr_en_in && read_only);

    // Write-value computation for RW/RS/RC and their immediate forms.
    always_comb begin
        src = csr_op_in[2] ? {27'b0, uimm_in} : rs1_in;
        case (csr_op_in[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = rdata;
        endcase
    end

    assign op_valid = (csr_op_in[1:0] != 2'b00);
    assign csr_we   = wr_en_in && op_valid && implemented && !read_only;

    // Next-state logic; later assignments win, giving trap > mret > CSR write.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mie_reg_d  = mie_reg_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (csr_we) begin
            case (csr_addr_in)
                ADDR_MSTATUS: begin
                    mie_d  = wdata[3];
                    mpie_d = wdata[7];
                end
                ADDR_MIE:      mie_reg_d  = wdata;
                ADDR_MTVEC:    mtvec_d    = wdata & ALIGN4_MASK;
                ADDR_MSCRATCH: mscratch_d = wdata;
                ADDR_MEPC:     mepc_d     = wdata & ALIGN4_MASK;
                ADDR_MCAUSE:   mcause_d   = wdata;
                default: ;
            endcase
        end

        if (mret_in) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (trap_in) begin
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mepc_d   = trap_pc_in & ALIGN4_MASK;
            mcause_d = trap_cause_in;
        end

        // A low-half write freezes the whole counter for that cycle; a
        // high-half write lets the low half count but drops its carry.
        if (csr_we && csr_addr_in == ADDR_MCYCLE)
            mcycle_d = {mcycle_q[63:32], wdata};
        else if (csr_we && csr_addr_in == ADDR_MCYCLEH)
            mcycle_d = {wdata, mcycle_q[31:0] + 32'd1};
        else
            mcycle_d = mcycle_q + 64'd1;

        if (csr_we && csr_addr_in == ADDR_MINSTRET)
            minstret_d = {minstret_q[63:32], wdata};
        else if (csr_we && csr_addr_in == ADDR_MINSTRETH)
            minstret_d = {wdata, minstret_q[31:0] + {31'b0, instret_inc_in}};
        else
            minstret_d = minstret_q + {63'b0, instret_inc_in};
    end

    // State registers with synchronous reset overriding all updates.
    always_ff @(posedge clk_in) begin
        // NOTE: state is assigned with <= so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (rst_in) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_reg_q  <= 32'h0;
            mtvec_q    <= RESET_MTVEC & ALIGN4_MASK;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mie_reg_q  <= mie_reg_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_out      = mtvec_q;
    assign mepc_out       = mepc_q;
    assign mie_global_out = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed, table-driven bench for csr_file, with hand-written
// sequences for reset, counter wrap/collision and mid-operation reset.
module tb_csr_file;

    logic        clk_in;
    logic        rst_in;
    logic        wr_en_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic [31:0] rs1_in;
    logic [4:0]  uimm_in;
    logic        instret_inc_in;
    logic        trap_in;
    logic [31:0] trap_cause_in;
    logic [31:0] trap_pc_in;
    logic        mret_in;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_global_out;

    int n_checks = 0;
    int n_fail   = 0;

    csr_file #(.RESET_MTVEC(32'h0000_0000)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .wr_en_in        (wr_en_in),
        .csr_addr_in     (csr_addr_in),
        .csr_op_in       (csr_op_in),
        .rs1_in          (rs1_in),
        .uimm_in         (uimm_in),
        .instret_inc_in  (instret_inc_in),
        .trap_in         (trap_in),
        .trap_cause_in   (trap_cause_in),
        .trap_pc_in      (trap_pc_in),
        .mret_in         (mret_in),
        .csr_data_out    (csr_data_out),
        .illegal_csr_out (illegal_csr_out),
        .mtvec_out       (mtvec_out),
        .mepc_out        (mepc_out),
        .mie_global_out  (mie_global_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        wr_en;
        logic [11:0] addr;
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [4:0]  uimm;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] OP_NONE = 3'b000, OP_RW  = 3'b001, OP_RS  = 3'b010,
                           OP_RC   = 3'b011, OP_BAD = 3'b100, OP_RWI = 3'b101,
                           OP_RSI  = 3'b110, OP_RCI = 3'b111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en_in       = 1'b0;
        csr_op_in      = OP_NONE;
        rs1_in         = 32'h0;
        uimm_in        = 5'h0;
        instret_inc_in = 1'b0;
        trap_in        = 1'b0;
        trap_cause_in  = 32'h0;
        trap_pc_in     = 32'h0;
        mret_in        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive a CSR write for one cycle (checks nothing).
    task automatic csr_write(input logic [11:0] addr, input logic [2:0] op,
                             input logic [31:0] rs1, input logic inc);
        idle();
        wr_en_in       = 1'b1;
        csr_addr_in    = addr;
        csr_op_in      = op;
        rs1_in         = rs1;
        instret_inc_in = inc;
        tick();
    endtask

    task automatic read_check(input string name, input logic [11:0] addr,
                              input logic [31:0] exp);
        csr_addr_in = addr;
        #1;
        check(name, csr_data_out, exp);
    endtask

    function automatic vec_t mk(input string name, input logic wr_en, input logic [11:0] addr,
                                input logic [2:0] op, input logic [31:0] rs1, input logic [4:0] uimm,
                                input logic trap, input logic [31:0] cause, input logic [31:0] pc,
                                input logic mret, input logic [31:0] exp_data, input logic exp_ill);
        vec_t v;
        v.name = name; v.wr_en = wr_en; v.addr = addr; v.op = op; v.rs1 = rs1;
        v.uimm = uimm; v.trap = trap; v.cause = cause; v.pc = pc; v.mret = mret;
        v.exp_data = exp_data; v.exp_ill = exp_ill;
        return v;
    endfunction

    initial begin
        idle();
        csr_addr_in = 12'h300;
        rst_in      = 1'b1;

        // ---------------- Reset ----------------
        tick();
        tick();
        rst_in = 1'b0;
        read_check("rst_mstatus", 12'h300, 32'h0000_1800);
        read_check("rst_mtvec", 12'h305, 32'h0000_0000);
        check("rst_mtvec_out", mtvec_out, 32'h0);
        check("rst_mepc_out", mepc_out, 32'h0);
        check("rst_mie_global", {31'b0, mie_global_out}, 32'h0);
        read_check("rst_mcycle0", 12'hB00, 32'h0);
        tick();
        read_check("rst_mcycle1", 12'hB00, 32'h1);
        read_check("rst_cycle_alias", 12'hC00, 32'h1);

        // ---------------- Vector table ----------------
        //                name          we    addr     op      rs1           uimm   trp cause         pc            mrt exp_data      ill
        vecs.push_back(mk("rw_scr",     1'b1, 12'h340, OP_RW,  32'hA5A5_0000, 5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        vecs.push_back(mk("rsi_scr",    1'b1, 12'h340, OP_RSI, 32'h0,        5'h0F, 0, 32'h0,        32'h0,        0, 32'hA5A5_0000, 0));
        vecs.push_back(mk("rc_scr",     1'b1, 12'h340, OP_RC,  32'hA5A5_0000, 5'h00, 0, 32'h0,        32'h0,        0, 32'hA5A5_000F, 0));
        vecs.push_back(mk("rd_scr",     1'b0, 12'h340, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_000F, 0));
        vecs.push_back(mk("badop4",     1'b1, 12'h340, OP_BAD, 32'h123,      5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_000F, 0));
        vecs.push_back(mk("badop0",     1'b1, 12'h340, OP_NONE,32'h456,      5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_000F, 0));
        vecs.push_back(mk("rd_scr2",    1'b0, 12'h340, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_000F, 0));
        vecs.push_back(mk("set_mie",    1'b1, 12'h300, OP_RSI, 32'h0,        5'h08, 0, 32'h0,        32'h0,        0, 32'h0000_1800, 0));
        vecs.push_back(mk("rd_mst1",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1808, 0));
        vecs.push_back(mk("trap",       1'b0, 12'h341, OP_NONE,32'h0,        5'h00, 1, 32'h8000_000B, 32'h0000_1236, 0, 32'h0,        0));
        vecs.push_back(mk("rd_mepc",    1'b0, 12'h341, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1234, 0));
        vecs.push_back(mk("rd_mcause",  1'b0, 12'h342, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h8000_000B, 0));
        vecs.push_back(mk("mret",       1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        1, 32'h0000_1880, 0));
        vecs.push_back(mk("rd_mst2",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1888, 0));
        vecs.push_back(mk("trap_all",   1'b1, 12'h341, OP_RW,  32'hFFFF_FFF0, 5'h00, 1, 32'h0000_0002, 32'h0000_4000, 1, 32'h0000_1234, 0));
        vecs.push_back(mk("rd_mepc2",   1'b0, 12'h341, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_4000, 0));
        vecs.push_back(mk("rd_mst3",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1880, 0));
        vecs.push_back(mk("rd_mcause2", 1'b0, 12'h342, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_0002, 0));
        vecs.push_back(mk("wr_misa",    1'b1, 12'h301, OP_RW,  32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h4000_0100, 1));
        vecs.push_back(mk("rd_misa",    1'b0, 12'h301, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h4000_0100, 0));
        vecs.push_back(mk("rd_unimpl",  1'b0, 12'h7C0, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        1));
        vecs.push_back(mk("wr_unimpl",  1'b1, 12'h7C0, OP_RW,  32'hFFFF,     5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        1));
        vecs.push_back(mk("wr_hartid",  1'b1, 12'hF14, OP_RW,  32'h5,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        1));
        vecs.push_back(mk("rd_hartid",  1'b0, 12'hF14, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        vecs.push_back(mk("wr_mtvec",   1'b1, 12'h305, OP_RW,  32'h8000_0103, 5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        vecs.push_back(mk("rd_mtvec",   1'b0, 12'h305, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h8000_0100, 0));
        vecs.push_back(mk("wr_mie",     1'b1, 12'h304, OP_RW,  32'hFFFF_FFFF, 5'h00, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        vecs.push_back(mk("rci_mie",    1'b1, 12'h304, OP_RCI, 32'h0,        5'h1F, 0, 32'h0,        32'h0,        0, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk("rd_mie",     1'b0, 12'h304, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'hFFFF_FFE0, 0));
        vecs.push_back(mk("rwi_scr",    1'b1, 12'h340, OP_RWI, 32'hFFFF_FFFF, 5'h1A, 0, 32'h0,        32'h0,        0, 32'h0000_000F, 0));
        vecs.push_back(mk("rd_scr3",    1'b0, 12'h340, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_001A, 0));
        vecs.push_back(mk("wr_mepc",    1'b1, 12'h341, OP_RW,  32'h0000_0007, 5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_4000, 0));
        vecs.push_back(mk("rs_mst",     1'b1, 12'h300, OP_RS,  32'h0000_0008, 5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1880, 0));
        vecs.push_back(mk("rd_mst4",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1888, 0));
        vecs.push_back(mk("rd_mepc3",   1'b0, 12'h341, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_0004, 0));
        vecs.push_back(mk("clr_mst",    1'b1, 12'h300, OP_RW,  32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1888, 0));
        vecs.push_back(mk("rd_mst5",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1800, 0));
        vecs.push_back(mk("mret_wr",    1'b1, 12'h340, OP_RW,  32'h0000_0077, 5'h00, 0, 32'h0,        32'h0,        1, 32'h0000_001A, 0));
        vecs.push_back(mk("rd_scr4",    1'b0, 12'h340, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_0077, 0));
        vecs.push_back(mk("rd_mst6",    1'b0, 12'h300, OP_NONE,32'h0,        5'h00, 0, 32'h0,        32'h0,        0, 32'h0000_1880, 0));

        foreach (vecs[i]) begin
            wr_en_in       = vecs[i].wr_en;
            csr_addr_in    = vecs[i].addr;
            csr_op_in      = vecs[i].op;
            rs1_in         = vecs[i].rs1;
            uimm_in        = vecs[i].uimm;
            trap_in        = vecs[i].trap;
            trap_cause_in  = vecs[i].cause;
            trap_pc_in     = vecs[i].pc;
            mret_in        = vecs[i].mret;
            instret_inc_in = 1'b0;
            #1;
            check({vecs[i].name, "_data"}, csr_data_out, vecs[i].exp_data);
            check({vecs[i].name, "_ill"}, {31'b0, illegal_csr_out}, {31'b0, vecs[i].exp_ill});
            tick();
        end
        idle();

        check("end_mtvec_out", mtvec_out, 32'h8000_0100);
        check("end_mepc_out", mepc_out, 32'h0000_0004);
        check("end_mie_global", {31'b0, mie_global_out}, 32'h0);

        // ---------------- mcycle wrap ----------------
        csr_write(12'hB80, OP_RW, 32'hFFFF_FFFF, 1'b0);
        csr_write(12'hB00, OP_RW, 32'hFFFF_FFFF, 1'b0);
        idle();
        read_check("wrap_lo_max", 12'hB00, 32'hFFFF_FFFF);
        read_check("wrap_hi_max", 12'hB80, 32'hFFFF_FFFF);
        tick();
        read_check("wrap_lo_zero", 12'hB00, 32'h0);
        read_check("wrap_hi_zero", 12'hB80, 32'h0);
        read_check("wrap_alias_lo", 12'hC00, 32'h0);
        tick();
        // Write to read-only alias is dropped while the counter keeps going.
        wr_en_in  = 1'b1;
        csr_op_in = OP_RW;
        rs1_in    = 32'h1234;
        csr_addr_in = 12'hC00;
        #1;
        check("wr_cycle_data", csr_data_out, 32'h1);
        check("wr_cycle_ill", {31'b0, illegal_csr_out}, 32'h1);
        tick();
        idle();
        read_check("cycle_unchanged", 12'hC00, 32'h2);
        read_check("cycleh_zero", 12'hC80, 32'h0);

        // High-half write drops the low half's carry.
        csr_write(12'hB00, OP_RW, 32'hFFFF_FFFF, 1'b0);
        csr_write(12'hB80, OP_RW, 32'h0000_0005, 1'b0);
        idle();
        read_check("carry_drop_lo", 12'hB00, 32'h0);
        read_check("carry_drop_hi", 12'hB80, 32'h0000_0005);

        // ---------------- minstret ----------------
        csr_write(12'hB02, OP_RW, 32'h0, 1'b1);
        csr_write(12'hB82, OP_RW, 32'h0, 1'b0);
        idle();
        read_check("inst_zero", 12'hB02, 32'h0);
        instret_inc_in = 1'b1; tick();
        instret_inc_in = 1'b0; tick(); tick();
        instret_inc_in = 1'b1; tick(); tick();
        instret_inc_in = 1'b0;
        read_check("inst_three", 12'hB02, 32'h3);
        read_check("inst_alias", 12'hC02, 32'h3);
        csr_write(12'hB82, OP_RW, 32'hFFFF_FFFF, 1'b1);
        idle();
        read_check("inst_hi_wr_lo", 12'hB02, 32'h4);
        csr_write(12'hB02, OP_RW, 32'hFFFF_FFFF, 1'b1);
        idle();
        read_check("inst_lo_frozen", 12'hB02, 32'hFFFF_FFFF);
        read_check("inst_hi_max", 12'hC82, 32'hFFFF_FFFF);
        instret_inc_in = 1'b1; tick();
        instret_inc_in = 1'b0;
        read_check("inst_wrap_lo", 12'hB02, 32'h0);
        read_check("inst_wrap_hi", 12'hB82, 32'h0);

        // ---------------- Reset mid-operation ----------------
        idle();
        rst_in        = 1'b1;
        wr_en_in      = 1'b1;
        csr_addr_in   = 12'h340;
        csr_op_in     = OP_RW;
        rs1_in        = 32'hDEAD_BEEF;
        trap_in       = 1'b1;
        trap_pc_in    = 32'h0000_8888;
        trap_cause_in = 32'h7;
        tick();
        idle();
        rst_in = 1'b0;
        read_check("rst2_scr", 12'h340, 32'h0);
        read_check("rst2_mst", 12'h300, 32'h0000_1800);
        read_check("rst2_mcause", 12'h342, 32'h0);
        read_check("rst2_mcycle", 12'hB00, 32'h0);
        read_check("rst2_mie", 12'h304, 32'h0);
        check("rst2_mepc_out", mepc_out, 32'h0);
        check("rst2_mtvec_out", mtvec_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
